// File: rtl/approx_add_pipe.sv
// Two-stage pipelined W-bit adder with selectable exact / lower-part-OR / truncated modes.
// Also accumulates on-chip error statistics (worst-case error, error count) against the exact sum.
module approx_add_pipe #(
  parameter int W     = 8,
  parameter int K     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic [W:0]       out_err,
  input  logic             stat_clr,
  output logic [W:0]       stat_max_err,
  output logic [CNT_W-1:0] stat_err_cnt
);

  localparam int         KM1   = (K > 0) ? K - 1 : 0;
  localparam logic [W:0] LMASK = ((W+1)'(1) << K) - (W+1)'(1);

  // Upper part is added as a shifted-down field so K=0 and K=W need no special slicing.
  function automatic logic [W:0] f_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] mode);
    logic [W:0] ax;
    logic [W:0] bx;
    logic [W:0] lo;
    logic [W:0] hi;
    logic       cy;
    ax = {1'b0, a};
    bx = {1'b0, b};
    lo = (ax | bx) & LMASK;
    cy = (K > 0) ? (a[KM1] & b[KM1]) : 1'b0;
    hi = (ax >> K) + (bx >> K);
    case (mode)
      2'd1:    f_sum = ((hi + (W+1)'(cy)) << K) | lo;
      2'd2:    f_sum = hi << K;
      default: f_sum = ax + bx;
    endcase
  endfunction

  function automatic logic [W:0] f_absdiff(input logic [W:0] x, input logic [W:0] y);
    f_absdiff = (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt);
    f_sat_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  function automatic logic [W:0] f_max(input logic [W:0] x, input logic [W:0] y);
    f_max = (y > x) ? y : x;
  endfunction

  logic             r_vld_p1;
  logic [W-1:0]     r_a_p1;
  logic [W-1:0]     r_b_p1;
  logic [1:0]       r_mode_p1;
  logic             r_vld_p2;
  logic [W:0]       r_sum_p2;
  logic [W:0]       r_err_p2;
  logic [W:0]       r_max_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [W:0]       w_exact_p1;
  logic [W:0]       w_sum_p1;
  logic [W:0]       w_err_p1;

  assign w_s2_adv   = !r_vld_p2 | out_ready;
  assign w_s1_adv   = r_vld_p1 & w_s2_adv;
  assign in_ready   = !r_vld_p1 | w_s2_adv;
  assign w_in_hs    = in_valid & in_ready;
  assign w_out_hs   = r_vld_p2 & out_ready;

  assign w_exact_p1 = {1'b0, r_a_p1} + {1'b0, r_b_p1};
  assign w_sum_p1   = f_sum(r_a_p1, r_b_p1, r_mode_p1);
  assign w_err_p1   = f_absdiff(w_exact_p1, w_sum_p1);

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_a_p1    <= in_a;
      r_b_p1    <= in_b;
      r_mode_p1 <= in_mode;
    end
  end

  // ---- stage 2: result and error registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_sum_p2 <= '0;
      r_err_p2 <= '0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (w_s1_adv) begin
        r_sum_p2 <= w_sum_p1;
        r_err_p2 <= w_err_p1;
      end
    end
  end

  // Clear takes priority over a coincident output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_err <= '0;
      r_err_cnt <= '0;
    end else if (stat_clr) begin
      r_max_err <= '0;
      r_err_cnt <= '0;
    end else if (w_out_hs) begin
      r_max_err <= f_max(r_max_err, r_err_p2);
      if (r_err_p2 != '0) begin
        r_err_cnt <= f_sat_inc(r_err_cnt);
      end
    end
  end

  assign out_valid    = r_vld_p2;
  assign out_sum      = r_sum_p2;
  assign out_err      = r_err_p2;
  assign stat_max_err = r_max_err;
  assign stat_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe: modes, backpressure, stat clear, counter saturation,
// K=W corner and asynchronous reset with data in flight.
module tb_approx_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, stat_clr;
  logic [7:0]  in_a, in_b;
  logic [1:0]  in_mode;
  logic [8:0]  out_sum, out_err, stat_max_err;
  logic [15:0] stat_err_cnt;

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_stat_clr;
  logic [7:0]  d2_in_a, d2_in_b;
  logic [1:0]  d2_in_mode;
  logic [8:0]  d2_out_sum, d2_out_err, d2_stat_max_err;
  logic [1:0]  d2_stat_err_cnt;

  logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_stat_clr;
  logic [3:0]  d3_in_a, d3_in_b;
  logic [1:0]  d3_in_mode;
  logic [4:0]  d3_out_sum, d3_out_err, d3_stat_max_err;
  logic [15:0] d3_stat_err_cnt;

  approx_add_pipe #(.W(8), .K(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err), .stat_clr(stat_clr),
    .stat_max_err(stat_max_err), .stat_err_cnt(stat_err_cnt)
  );

  approx_add_pipe #(.W(8), .K(4), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_a(d2_in_a), .in_b(d2_in_b), .in_mode(d2_in_mode), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .out_sum(d2_out_sum), .out_err(d2_out_err),
    .stat_clr(d2_stat_clr), .stat_max_err(d2_stat_max_err), .stat_err_cnt(d2_stat_err_cnt)
  );

  approx_add_pipe #(.W(4), .K(4), .CNT_W(16)) u_dut_kw (
    .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_a(d3_in_a), .in_b(d3_in_b), .in_mode(d3_in_mode), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .out_sum(d3_out_sum), .out_err(d3_out_err),
    .stat_clr(d3_stat_clr), .stat_max_err(d3_stat_max_err), .stat_err_cnt(d3_stat_err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] va [8];
  logic [7:0] vb [8];
  logic [1:0] vm [8];
  logic [8:0] es [8];
  logic [8:0] ee [8];

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] m, input logic [8:0] s, input logic [8:0] e);
    va[i] = a; vb[i] = b; vm[i] = m; es[i] = s; ee[i] = e;
  endtask

  // Entered and left #1 after a rising edge; streams n vectors with an optional stall window.
  task automatic run(input string tag, input int n, input int st0, input int stn,
                     input bit chk_lat);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int acc_stall = 0;
    int in_cyc [8];
    bit held = 0;
    bit saw_nr = 0;
    logic [8:0] hsum, herr;
    while (got < n && cyc < 60) begin
      out_ready = !(cyc >= st0 && cyc < st0 + stn);
      in_valid  = (sent < n);
      if (sent < n) begin
        in_a = va[sent]; in_b = vb[sent]; in_mode = vm[sent];
      end
      #1;
      if (held) begin
        check({tag, "_hold_vld"}, out_valid, 1);
        check({tag, "_hold_sum"}, out_sum, hsum);
        check({tag, "_hold_err"}, out_err, herr);
      end
      if (out_valid && out_ready) begin
        check({tag, "_sum"}, out_sum, es[got]);
        check({tag, "_err"}, out_err, ee[got]);
        if (chk_lat) check({tag, "_lat"}, cyc - in_cyc[got], 2);
        got++;
      end
      held = out_valid && !out_ready;
      hsum = out_sum;
      herr = out_err;
      if (!out_ready && !in_ready) saw_nr = 1;
      if (in_valid && in_ready) begin
        if (!out_ready) acc_stall++;
        in_cyc[sent] = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_count"}, got, n);
    if (stn > 0) begin
      check({tag, "_in_ready_low"}, saw_nr, 1);
      check({tag, "_accept_le2"}, acc_stall <= 2, 1);
    end
    in_valid  = 0;
    out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] s3 [3];
    logic [4:0] e3 [3];
    logic [1:0] m3 [3];
    bit stale;
    rst_n = 0;
    in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; out_ready = 1; stat_clr = 0;
    d2_in_valid = 0; d2_in_a = 0; d2_in_b = 0; d2_in_mode = 0; d2_out_ready = 1; d2_stat_clr = 0;
    d3_in_valid = 0; d3_in_a = 0; d3_in_b = 0; d3_in_mode = 0; d3_out_ready = 1; d3_stat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_err", out_err, 0);
    check("rst_max", stat_max_err, 0);
    check("rst_cnt", stat_err_cnt, 0);
    rst_n = 1;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid2", out_valid, 0);

    set_vec(0, 8'h37, 8'h19, 2'd0, 9'h050, 9'd0);
    set_vec(1, 8'h37, 8'h19, 2'd1, 9'h04F, 9'd1);
    set_vec(2, 8'h37, 8'h19, 2'd2, 9'h040, 9'd16);
    run("modes", 3, 0, 0, 1);
    check("modes_max", stat_max_err, 16);
    check("modes_cnt", stat_err_cnt, 2);

    set_vec(0, 8'hFF, 8'hFF, 2'd0, 9'h1FE, 9'd0);
    set_vec(1, 8'hFF, 8'hFF, 2'd1, 9'h1FF, 9'd1);
    set_vec(2, 8'hFF, 8'hFF, 2'd2, 9'h1E0, 9'd30);
    set_vec(3, 8'hFF, 8'hFF, 2'd3, 9'h1FE, 9'd0);
    run("ff", 4, 0, 0, 1);
    check("ff_max", stat_max_err, 30);
    check("ff_cnt", stat_err_cnt, 4);

    set_vec(0, 8'h37, 8'h19, 2'd1, 9'h04F, 9'd1);
    set_vec(1, 8'h0F, 8'h01, 2'd2, 9'h000, 9'd16);
    set_vec(2, 8'h88, 8'h88, 2'd1, 9'h118, 9'd8);
    set_vec(3, 8'h12, 8'h34, 2'd0, 9'h046, 9'd0);
    run("bp", 4, 1, 5, 0);
    check("bp_max", stat_max_err, 30);
    check("bp_cnt", stat_err_cnt, 7);

    in_valid = 1; in_a = 8'h37; in_b = 8'h19; in_mode = 2'd2;
    tick();
    in_valid = 0;
    tick();
    check("clr_vld", out_valid, 1);
    check("clr_err16", out_err, 16);
    stat_clr = 1;
    tick();
    stat_clr = 0;
    check("clr_max", stat_max_err, 0);
    check("clr_cnt", stat_err_cnt, 0);
    in_valid = 1; in_mode = 2'd1;
    tick();
    in_valid = 0;
    tick();
    check("clr_err1", out_err, 1);
    tick();
    check("clr_post_max", stat_max_err, 1);
    check("clr_post_cnt", stat_err_cnt, 1);

    d2_in_a = 8'h37; d2_in_b = 8'h19; d2_in_mode = 2'd2; d2_in_valid = 1;
    repeat (5) tick();
    d2_in_valid = 0;
    repeat (4) tick();
    check("sat_cnt", d2_stat_err_cnt, 3);
    check("sat_max", d2_stat_max_err, 16);

    m3[0] = 2'd1; s3[0] = 5'h1F; e3[0] = 5'd7;
    m3[1] = 2'd2; s3[1] = 5'h00; e3[1] = 5'd24;
    m3[2] = 2'd0; s3[2] = 5'h18; e3[2] = 5'd0;
    d3_in_a = 4'hF; d3_in_b = 4'h9;
    for (int i = 0; i < 5; i++) begin
      d3_in_valid = (i < 3);
      if (i < 3) d3_in_mode = m3[i];
      tick();
      if (i >= 1 && i <= 3) begin
        check("kw_vld", d3_out_valid, 1);
        check("kw_sum", d3_out_sum, s3[i-1]);
        check("kw_err", d3_out_err, e3[i-1]);
      end
    end
    d3_in_valid = 0;
    tick();
    check("kw_max", d3_stat_max_err, 24);
    check("kw_cnt", d3_stat_err_cnt, 2);

    out_ready = 0;
    in_valid = 1; in_a = 8'h37; in_b = 8'h19; in_mode = 2'd1;
    tick();
    in_a = 8'h0F; in_b = 8'h01; in_mode = 2'd2;
    tick();
    in_valid = 0;
    check("ar_pre_vld", out_valid, 1);
    #3;
    rst_n = 0;
    #1;
    check("ar_vld", out_valid, 0);
    check("ar_sum", out_sum, 0);
    check("ar_err", out_err, 0);
    check("ar_max", stat_max_err, 0);
    check("ar_cnt", stat_err_cnt, 0);
    #2;
    rst_n = 1;
    out_ready = 1;
    stale = 0;
    repeat (6) begin
      tick();
      if (out_valid) stale = 1;
    end
    check("ar_no_stale", stale, 0);
    check("ar_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
